// File: rtl/hwpe_dbg_monitor.sv
// ---------------------------------------------------------------------------
// hwpe_dbg_monitor
//
// Debug / performance-monitor slave for an HWPE engine controller. It answers
// the debug address window of the peripheral port (already decoded upstream)
// and exposes:
//   word 0              CTRL   (write: bit0 clear counters, bit1 freeze level)
//   word 1              STATUS (frozen, live busy, overflow flags)
//   word 2              CYCLES (busy cycles)
//   words 3..2+NS       STALL[k] (cycles with valid=1 and ready=0 on stream k)
//   next N_PROBES words PROBE[j] (live probe word, or snapshot while frozen)
// Counters saturate and set a sticky overflow flag on the first lost count.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous soft clear from the controller slave
//   busy_i                   engine busy (FSM not idle)
//   strm_valid_i/ready_i     per-stream handshake, monitored for stalls
//   probe_i                  N_PROBES live 32-bit probe words
//   periph_*_i               request side of the peripheral port
//   periph_gnt_o             always granted
//   periph_r_*_o             registered response, one cycle after the request
// ---------------------------------------------------------------------------
module hwpe_dbg_monitor #(
    parameter int N_PROBES  = 6,
    parameter int N_STREAMS = 4,
    parameter int CNT_WIDTH = 32,
    parameter int ID_WIDTH  = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      busy_i,
    input  logic [N_STREAMS-1:0]      strm_valid_i,
    input  logic [N_STREAMS-1:0]      strm_ready_i,
    input  logic [N_PROBES*32-1:0]    probe_i,
    input  logic                      periph_req_i,
    input  logic [31:0]               periph_add_i,
    input  logic                      periph_wen_i,
    input  logic [3:0]                periph_be_i,
    input  logic [31:0]               periph_data_i,
    input  logic [ID_WIDTH-1:0]       periph_id_i,
    output logic                      periph_gnt_o,
    output logic [31:0]               periph_r_data_o,
    output logic                      periph_r_valid_o,
    output logic [ID_WIDTH-1:0]       periph_r_id_o
);

    localparam int N_WORDS = 3 + N_STREAMS + N_PROBES;
    localparam int IDX_W   = $clog2(N_WORDS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0]                 cycles_q, cycles_d;
    logic                                 cyc_ovf_q, cyc_ovf_d;
    logic [N_STREAMS-1:0][CNT_WIDTH-1:0]  stall_q, stall_d;
    logic [N_STREAMS-1:0]                 stall_ovf_q, stall_ovf_d;
    logic                                 frozen_q, frozen_d;
    logic [N_PROBES-1:0][31:0]            snap_q, snap_d;
    logic                                 r_valid_q, r_valid_d;
    logic [31:0]                          r_data_q, r_data_d;
    logic [ID_WIDTH-1:0]                  r_id_q, r_id_d;

    logic [IDX_W-1:0] idx;
    logic             ctrl_wr;
    logic [31:0]      status_word;
    logic [31:0]      read_word;
    logic             unused_bits;

    // Upper address bits alias onto the window; only the word index matters.
    assign idx     = periph_add_i[2 +: IDX_W];
    assign ctrl_wr = periph_req_i && !periph_wen_i && (idx == '0) && periph_be_i[0];

    assign unused_bits = ^{periph_add_i, periph_be_i, periph_data_i};

    // Read mux, sampled in the request cycle so counters read pre-update.
    always_comb begin
        status_word                 = '0;
        status_word[0]              = frozen_q;
        status_word[1]              = busy_i;
        status_word[8]              = cyc_ovf_q;
        status_word[9 +: N_STREAMS] = stall_ovf_q;

        read_word = '0;
        if (idx == IDX_W'(1)) read_word = status_word;
        if (idx == IDX_W'(2)) read_word = 32'(cycles_q);
        for (int k = 0; k < N_STREAMS; k++) begin
            if (idx == IDX_W'(3 + k)) read_word = 32'(stall_q[k]);
        end
        for (int j = 0; j < N_PROBES; j++) begin
            if (idx == IDX_W'(3 + N_STREAMS + j)) begin
                read_word = frozen_q ? snap_q[j] : probe_i[j*32 +: 32];
            end
        end
    end

    // Counter, freeze and snapshot next-state. Priority, lowest to highest:
    // increment, CTRL clear, then soft clear which resets everything.
    always_comb begin
        cycles_d    = cycles_q;
        cyc_ovf_d   = cyc_ovf_q;
        stall_d     = stall_q;
        stall_ovf_d = stall_ovf_q;
        frozen_d    = frozen_q;
        snap_d      = snap_q;

        if (!frozen_q) begin
            if (busy_i) begin
                if (cycles_q == CNT_MAX) cyc_ovf_d = 1'b1;
                else                     cycles_d  = cycles_q + CNT_WIDTH'(1);
            end
            for (int k = 0; k < N_STREAMS; k++) begin
                if (strm_valid_i[k] && !strm_ready_i[k]) begin
                    if (stall_q[k] == CNT_MAX) stall_ovf_d[k] = 1'b1;
                    else                       stall_d[k]     = stall_q[k] + CNT_WIDTH'(1);
                end
            end
        end

        if (ctrl_wr && periph_data_i[0]) begin
            cycles_d    = '0;
            cyc_ovf_d   = 1'b0;
            stall_d     = '0;
            stall_ovf_d = '0;
        end

        // Snapshot only on the unfrozen-to-frozen transition.
        if (ctrl_wr) begin
            if (periph_data_i[1] && !frozen_q) snap_d = probe_i;
            frozen_d = periph_data_i[1];
        end

        if (clear_i) begin
            cycles_d    = '0;
            cyc_ovf_d   = 1'b0;
            stall_d     = '0;
            stall_ovf_d = '0;
            frozen_d    = 1'b0;
            snap_d      = '0;
        end
    end

    // Response path is left alone by clear_i so in-flight responses complete.
    always_comb begin
        r_valid_d = periph_req_i;
        r_id_d    = periph_req_i ? periph_id_i : '0;
        r_data_d  = (periph_req_i && periph_wen_i) ? read_word : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles_q    <= '0;
            cyc_ovf_q   <= 1'b0;
            stall_q     <= '0;
            stall_ovf_q <= '0;
            frozen_q    <= 1'b0;
            snap_q      <= '0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_id_q      <= '0;
        end else begin
            cycles_q    <= cycles_d;
            cyc_ovf_q   <= cyc_ovf_d;
            stall_q     <= stall_d;
            stall_ovf_q <= stall_ovf_d;
            frozen_q    <= frozen_d;
            snap_q      <= snap_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            r_id_q      <= r_id_d;
        end
    end

    assign periph_gnt_o     = 1'b1;
    assign periph_r_valid_o = r_valid_q;
    assign periph_r_data_o  = r_data_q;
    assign periph_r_id_o    = r_id_q;

endmodule

// File: tb/tb_hwpe_dbg_monitor.sv
// ---------------------------------------------------------------------------
// tb_hwpe_dbg_monitor
//
// Drives hwpe_dbg_monitor (8-bit counters so saturation is reachable) with a
// directed sequence followed by randomized traffic. A behavioural model of
// the register map tracks the expected counters, flags, freeze and snapshot
// state and the expected response of every cycle.
// ---------------------------------------------------------------------------
module tb_hwpe_dbg_monitor;

    localparam int NP   = 6;
    localparam int NS   = 4;
    localparam int CW   = 8;
    localparam int IW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rstN;
    logic              clearIn;
    logic              busy;
    logic [NS-1:0]     valid;
    logic [NS-1:0]     ready;
    logic [NP*32-1:0]  probe;
    logic              req;
    logic [31:0]       addr;
    logic              wen;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [IW-1:0]     reqId;
    logic              gnt;
    logic [31:0]       rData;
    logic              rValid;
    logic [IW-1:0]     rId;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state
    int unsigned mCyc;
    bit          mCycOvf;
    int unsigned mStall [NS];
    bit          mStallOvf [NS];
    bit          mFrozen;
    logic [31:0] mSnap [NP];

    bit          expValid;
    logic [31:0] expData;
    logic [IW-1:0] expId;

    hwpe_dbg_monitor #(
        .N_PROBES (NP),
        .N_STREAMS(NS),
        .CNT_WIDTH(CW),
        .ID_WIDTH (IW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .clear_i         (clearIn),
        .busy_i          (busy),
        .strm_valid_i    (valid),
        .strm_ready_i    (ready),
        .probe_i         (probe),
        .periph_req_i    (req),
        .periph_add_i    (addr),
        .periph_wen_i    (wen),
        .periph_be_i     (be),
        .periph_data_i   (wdata),
        .periph_id_i     (reqId),
        .periph_gnt_o    (gnt),
        .periph_r_data_o (rData),
        .periph_r_valid_o(rValid),
        .periph_r_id_o   (rId)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelRead(input int idx);
        logic [31:0] s;
        s = '0;
        if (idx == 1) begin
            s[0] = mFrozen;
            s[1] = busy;
            s[8] = mCycOvf;
            for (int k = 0; k < NS; k++) s[9+k] = mStallOvf[k];
        end else if (idx == 2) begin
            s = mCyc;
        end else if (idx >= 3 && idx < 3 + NS) begin
            s = mStall[idx-3];
        end else if (idx >= 3 + NS && idx < 3 + NS + NP) begin
            s = mFrozen ? mSnap[idx-3-NS] : probe[(idx-3-NS)*32 +: 32];
        end
        return s;
    endfunction

    task automatic modelClearCounters();
        mCyc    = 0;
        mCycOvf = 0;
        for (int k = 0; k < NS; k++) begin
            mStall[k]    = 0;
            mStallOvf[k] = 0;
        end
    endtask

    // Compute this cycle's response and advance the model from current inputs.
    task automatic modelStep();
        int  idx;
        bit  ctrlWr;
        idx      = int'(addr[5:2]);
        expValid = req;
        expId    = reqId;
        expData  = (req && wen) ? modelRead(idx) : 32'h0;
        if (clearIn) begin
            modelClearCounters();
            mFrozen = 0;
            for (int j = 0; j < NP; j++) mSnap[j] = '0;
        end else begin
            if (!mFrozen) begin
                if (busy) begin
                    if (mCyc == CMAX) mCycOvf = 1;
                    else mCyc++;
                end
                for (int k = 0; k < NS; k++) begin
                    if (valid[k] && !ready[k]) begin
                        if (mStall[k] == CMAX) mStallOvf[k] = 1;
                        else mStall[k]++;
                    end
                end
            end
            ctrlWr = req && !wen && idx == 0 && be[0];
            if (ctrlWr && wdata[0]) modelClearCounters();
            if (ctrlWr) begin
                if (wdata[1] && !mFrozen)
                    for (int j = 0; j < NP; j++) mSnap[j] = probe[j*32 +: 32];
                mFrozen = wdata[1];
            end
        end
    endtask

    // One clock: model, edge, then compare all meaningful outputs.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("gnt", 32'(gnt), 32'h1);
        checkOutput("r_valid", 32'(rValid), 32'(expValid));
        if (expValid) begin
            checkOutput("r_data", rData, expData);
            checkOutput("r_id", 32'(rId), 32'(expId));
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic doRead(input int idx, input logic [IW-1:0] id, output logic [31:0] d);
        req   = 1'b1;
        wen   = 1'b1;
        addr  = 32'(idx) << 2;
        reqId = id;
        applyStimulus();
        d   = rData;
        req = 1'b0;
    endtask

    task automatic doWrite(input int idx, input logic [31:0] d);
        req   = 1'b1;
        wen   = 1'b0;
        be    = 4'hF;
        addr  = 32'(idx) << 2;
        wdata = d;
        reqId = IW'($urandom);
        applyStimulus();
        req = 1'b0;
    endtask

    task automatic setProbe0(input logic [31:0] v);
        probe[31:0] = v;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] d2, d3, d4;
        int idx;

        rstN = 1'b0; clearIn = 1'b0; busy = 1'b0; valid = '0; ready = '0;
        probe = '0; req = 1'b0; addr = '0; wen = 1'b1; be = 4'hF; wdata = '0; reqId = '0;
        mFrozen = 0;
        modelClearCounters();
        for (int j = 0; j < NP; j++) mSnap[j] = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset r_valid", 32'(rValid), 32'h0);
        checkOutput("reset r_data", rData, 32'h0);
        checkOutput("reset r_id", 32'(rId), 32'h0);
        rstN = 1'b1;

        // First read after reset, id echoed
        doRead(2, IW'(10'h2A), d);
        checkOutput("first CYCLES", d, 32'h0);
        checkOutput("first r_id", 32'(rId), 32'h2A);

        // Busy counting and stream stall
        busy = 1'b1;
        idleCycles(100);
        busy = 1'b0;
        doRead(2, IW'(1), d);
        checkOutput("CYCLES after 100", d, 32'd100);
        valid = 4'b0010;
        idleCycles(7);
        valid = '0;
        doRead(4, IW'(2), d);
        checkOutput("STALL1", d, 32'd7);
        doRead(3, IW'(3), d);
        checkOutput("STALL0", d, 32'd0);
        doRead(6, IW'(4), d);
        checkOutput("STALL3", d, 32'd0);

        // Saturation and CTRL clear
        busy = 1'b1;
        idleCycles(300);
        busy = 1'b0;
        doRead(2, IW'(5), d);
        checkOutput("CYCLES saturated", d, 32'hFF);
        doRead(1, IW'(6), d);
        checkOutput("STATUS ovf", d, 32'h100);
        doWrite(0, 32'h1);
        doRead(2, IW'(7), d);
        checkOutput("CYCLES cleared", d, 32'h0);
        doRead(1, IW'(8), d);
        checkOutput("STATUS cleared", d, 32'h0);

        // Freeze / snapshot
        setProbe0(32'h5);
        doWrite(0, 32'h2);
        setProbe0(32'h9);
        busy = 1'b1;
        idleCycles(5);
        doRead(7, IW'(9), d);
        checkOutput("PROBE0 frozen", d, 32'h5);
        doRead(1, IW'(10), d);
        checkOutput("STATUS frozen", d, 32'h3);
        doRead(2, IW'(11), d);
        checkOutput("CYCLES held", d, 32'h0);
        doWrite(0, 32'h2);
        setProbe0(32'h7);
        doRead(7, IW'(12), d);
        checkOutput("PROBE0 no recapture", d, 32'h5);
        busy = 1'b0;
        doWrite(0, 32'h0);
        doRead(7, IW'(13), d);
        checkOutput("PROBE0 live", d, 32'h7);

        // Back-to-back reads while counters run
        busy = 1'b1; valid = 4'b0011; ready = 4'b0000;
        idleCycles(10);
        doRead(2, IW'(14), d2);
        doRead(3, IW'(15), d3);
        doRead(4, IW'(16), d4);
        checkOutput("b2b CYCLES", d2, 32'd10);
        checkOutput("b2b STALL0", d3, 32'd11);
        checkOutput("b2b STALL1", d4, 32'd12);
        busy = 1'b0; valid = '0;
        req = 1'b1; wen = 1'b1; addr = 32'hABCD_0038; reqId = IW'(17);
        applyStimulus();
        req = 1'b0;
        checkOutput("unmapped read", rData, 32'h0);

        // CTRL clear coincident with an increment
        busy = 1'b1;
        doWrite(0, 32'h1);
        busy = 1'b0;
        doRead(2, IW'(18), d);
        checkOutput("clear wins", d, 32'h0);

        // Soft clear while a response is pending
        busy = 1'b1; valid = 4'b1111; ready = '0;
        idleCycles(20);
        doRead(2, IW'(19), d);
        checkOutput("pre-clear CYCLES", d, 32'd20);
        clearIn = 1'b1;
        busy = 1'b0; valid = '0;
        idleCycles(1);
        clearIn = 1'b0;
        doRead(2, IW'(20), d);
        checkOutput("clear_i CYCLES", d, 32'h0);
        doRead(5, IW'(21), d);
        checkOutput("clear_i STALL2", d, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            busy    = 1'($urandom);
            valid   = NS'($urandom);
            ready   = NS'($urandom);
            if ($urandom_range(0, 7) == 0)
                for (int j = 0; j < NP; j++) probe[j*32 +: 32] = $urandom;
            clearIn = ($urandom_range(0, 199) == 0);
            req     = !clearIn && ($urandom_range(0, 1) == 1);
            wen     = ($urandom_range(0, 9) != 0);
            idx     = wen ? $urandom_range(0, 15) : (($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0);
            addr    = ($urandom & 32'hFFFF_FFC3) | (32'(idx) << 2);
            be      = 4'($urandom);
            wdata   = $urandom;
            reqId   = IW'($urandom);
            applyStimulus();
        end
        req = 1'b0; clearIn = 1'b0;
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hwpe_dbg_monitor.md
Name: hwpe_dbg_monitor

Overview:
Parametrised debug/performance-monitor slave for HWPE accelerator controllers. It serves the debug address window of the peripheral port, which is already decoded upstream.
- Generalises a fixed 6-entry live status mux to N_PROBES probe words.
- Adds busy-cycle and per-stream stall counters, with saturation and sticky overflow flags.
- Adds freeze/snapshot and software clear.
- Sits inside the engine controller beside hwpe_ctrl_slave; fed by FSM state, engine counters and streamer handshakes.

Parameters:
N_PROBES, 6, number of 32-bit probe words (1..16)
N_STREAMS, 4, number of stream channels monitored for stalls (1..23)
CNT_WIDTH, 32, counter width (8..32), zero-extended on read
ID_WIDTH, 10, periph transaction ID width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear from controller slave
busy_i  in  1  engine busy (FSM not idle)
strm_valid_i  in  N_STREAMS  per-stream valid
strm_ready_i  in  N_STREAMS  per-stream ready
probe_i  in  N_PROBES*32  live probe words (FSM state, engine count, stream addresses...)
periph_req_i  in  1  request, already qualified to the debug window
periph_add_i  in  32  byte address
periph_wen_i  in  1  1 = read, 0 = write
periph_be_i  in  4  byte enables
periph_data_i  in  32  write data
periph_id_i  in  ID_WIDTH  transaction ID
periph_gnt_o  out  1  grant
periph_r_data_o  out  32  response data
periph_r_valid_o  out  1  response valid
periph_r_id_o  out  ID_WIDTH  response ID

Behaviour:
Reset and clear:
- rst_ni low (async): all counters, overflow flags, freeze, snapshot regs, r_valid, r_data and r_id are 0.
- clear_i has the same effect synchronously, except that a response already registered is still delivered.

Handshake:
- periph_gnt_o is hardwired to 1.
- Every accepted request (read or write) produces r_valid=1 exactly 1 cycle later, with r_id = the captured id. Back-to-back requests are supported every cycle.
- Read data is sampled in the request cycle, so a read returns the pre-update value of a counter incrementing that cycle.
- Write responses carry r_data=0.

Register map:
- Word index = add[2 +: IDX_W], IDX_W = clog2(3+N_STREAMS+N_PROBES). Higher bits are ignored (aliasing).
- 0 CTRL (W; reads 0): acts only if be[0]=1. bit0 = clear counters and overflow flags; bit1 = freeze level.
- 1 STATUS (R): bit0 frozen, bit1 live busy_i, bit8 cycle-overflow, bits[9 +: N_STREAMS] stall-overflow.
- 2 CYCLES (R): cycles with busy_i=1.
- 3..2+N_STREAMS: STALL[k] (R), cycles with valid[k]=1 and ready[k]=0.
- next N_PROBES words: PROBE[j] (R). Returns live probe_i when not frozen, snapshot when frozen.
- Unmapped index: read 0, write ignored.

Counters:
- Increment by 1 per qualifying cycle only while not frozen.
- Saturate at 2^CNT_WIDTH-1. The increment attempt at saturation sets the sticky overflow bit.
- A CTRL clear write in the same cycle as an increment: clear wins, counter = 0 next cycle.

Freeze:
- A CTRL write with bit1=1 while unfrozen sets frozen next cycle and captures all probe_i words in that same (write) cycle.
- A bit1=1 write while already frozen does not recapture.
- A bit1=0 write unfreezes.
- A write with bit0=1 and bit1=1 clears and freezes together.

Test Plan:
- Reset then read idx 2 -> r_valid on cycle+1, data 0x0, r_id echoed (e.g. id=0x2A -> 0x2A).
- busy_i high 100 cycles, read CYCLES -> 100. Stream 1 valid=1 ready=0 for 7 cycles -> STALL[1]=7, other STALLs 0.
- CNT_WIDTH=8, busy_i high 300 cycles -> CYCLES=0xFF, STATUS bit8=1. Write CTRL=0x1 -> CYCLES=0, bit8=0.
- probe_i[0]=0x5 at freeze write, then changes to 0x9 -> PROBE[0] reads 0x5, STATUS bit0=1, counters hold. Unfreeze -> PROBE[0] reads 0x9.
- Back-to-back reads idx 2,3,4 on consecutive cycles -> three consecutive r_valid, data in order. Read of an unmapped index -> 0.
- Clear write coincident with busy_i increment -> CYCLES reads 0. clear_i asserted mid-run -> all counters 0, pending response still returned.
